cpu_controller: RTL
===================

# cpu_controller

Instruction-sequencing controller for the 8-bit accumulator CPU. It consumes the 3-bit instruction opcode, which is also the ALU opcode, and the ALU `zero` flag. It steps an 8-phase instruction cycle and drives every datapath control strobe: memory mux select, memory read/write, IR load, PC increment/load, accumulator load, data-bus enable and halt. It sits between the instruction register/ALU and the PC, IR, accumulator and memory.

## Interface
Parameters:
- none. Opcode and phase encodings come from the shared package.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_`  in  1  reset, asynchronous assert, active-low
- `opcode`  in  3  current opcode from the instruction register
- `zero`  in  1  ALU zero flag (accumulator == 0)
- `sel`  out  1  address mux: 1 = PC, 0 = IR operand
- `rd`  out  1  memory read
- `wr`  out  1  memory write
- `ld_ir`  out  1  load instruction register
- `ld_ac`  out  1  load accumulator from ALU output
- `ld_pc`  out  1  load PC from IR operand
- `inc_pc`  out  1  increment PC
- `data_e`  out  1  drive accumulator onto data bus
- `halt`  out  1  CPU halted (sticky until reset)
- `phase`  out  3  current phase, for debug and bench

## Operation
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- `aluop` = ADD | AND | XOR | LDA.
- Phases advance in order 0→7, then wrap to 0:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- Outputs are a decode of the registered phase plus `opcode`/`zero`. Any strobe not listed for a phase is 0.
  - INST_ADDR: `sel`=1.
  - INST_FETCH: `sel`=1, `rd`=1.
  - INST_LOAD and IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - OP_ADDR: `inc_pc`=1.
  - OP_FETCH: `rd`=aluop.
  - ALU_OP: `rd`=aluop; `inc_pc`=(SKZ & `zero`); `ld_pc`=JMP; `data_e`=STO.
  - STORE: `rd`=aluop; `ld_ac`=aluop; `ld_pc`=JMP; `inc_pc`=JMP; `data_e`=STO; `wr`=STO.
- HLT: when phase is OP_ADDR and `opcode`==HLT at a rising edge:
  - `halt` register sets.
  - Phase freezes at OP_ADDR.
  - While halted, every strobe other than `halt` is forced to 0, including `inc_pc`.
  - Only `rst_` leaves the halted state.
- SKZ with `zero`=0 performs no skip. `inc_pc` stays 0 in ALU_OP.

## Timing
- Reset (`rst_`=0, asynchronous): `phase`=0, `halt`=0. Combinational outputs then read `sel`=1, all other strobes 0.
- Reset deassertion: the first rising edge with `rst_`=1 moves phase 0→1.
- Reset applied mid-cycle aborts the instruction immediately. No pending write or load completes.
- One phase per clock, so one instruction takes 8 cycles. Strobes are valid from the phase register with zero added latency.
- `opcode` must be stable from phase 3 through phase 7. `zero` is sampled combinationally during ALU_OP.
- Phase 7 wraps to 0 with no idle cycle.

## Structure
- `cpu_pkg` holds:
  - opcode localparams, shared with the ALU and its bench;
  - phase encodings;
  - the `aluop` membership function.
- Sub-module `phase_counter` holds the 3-bit counter with async active-low reset and a hold input driven by the halt condition.
- Top level holds the halt register and the output decode.

## Test plan
- Reset: hold `rst_`=0 for 2 cycles → `phase`=0, `sel`=1, all other outputs 0. Release → phases 1..7,0 on successive edges.
- ADD (`opcode`=010) over one full cycle:
  - `ld_ir`=1 in phases 2–3;
  - `inc_pc`=1 in phase 4;
  - `rd`=1 in phases 5–7;
  - `ld_ac`=1 only in phase 7;
  - `wr`=0 throughout.
- STO (110): `data_e`=1 in phases 6–7, `wr`=1 only in phase 7, `rd`=0 in phases 5–7, `ld_ac`=0.
- SKZ (001):
  - `zero`=1 → `inc_pc`=1 in phase 6;
  - `zero`=0 → `inc_pc`=0 in phase 6;
  - the phase-4 `inc_pc` is present in both cases.
- JMP (111): `ld_pc`=1 in phases 6–7, `inc_pc`=1 in phase 7 only (beyond phase 4).
- HLT (000):
  - `halt` rises at the edge leaving phase 4, and `phase` stays 4 for 20 cycles with all strobes 0;
  - asserting `rst_`=0 mid-halt → `halt`=0, `phase`=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: opcodes, instruction-cycle
// phases and the ALU-opcode membership test.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes whose result is written back into the accumulator.
  function automatic logic aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// Free-running 3-bit instruction-phase counter with a hold input.
module phase_counter
  import cpu_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_hold,
  output phase_t o_phase
);

  phase_t r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_phase <= INST_ADDR;
    else if (!i_hold)
      r_phase <= phase_t'(r_phase + 3'd1);
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/cpu_controller.sv
// Instruction-sequencing controller: steps the 8-phase cycle and decodes the
// registered phase plus opcode/zero into datapath strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  phase_t w_phase;
  logic   w_hlt_now;
  logic   w_hold;
  logic   w_alu;
  logic   r_halt;

  assign w_hlt_now = (w_phase == OP_ADDR) && (opcode == OP_HLT);
  // Hold on the HLT edge itself so the phase freezes at OP_ADDR together with the halt flag.
  assign w_hold    = r_halt | w_hlt_now;
  assign w_alu     = aluop(opcode);

  phase_counter u_phase_counter (
    .i_clk   (clk),
    .i_rst_n (rst_),
    .i_hold  (w_hold),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      r_halt <= 1'b0;
    else if (w_hlt_now)
      r_halt <= 1'b1;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    if (!r_halt) begin
      case (w_phase)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    inc_pc = 1'b1;
        OP_FETCH:   rd = w_alu;
        ALU_OP: begin
          rd     = w_alu;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = w_alu;
          ld_ac  = w_alu;
          ld_pc  = (opcode == OP_JMP);
          inc_pc = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign halt  = r_halt;
  assign phase = w_phase;

endmodule
